// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - CPU/rate tick prescalers plus a bank of saturating down-counting timers
module timer_bank #(
    parameter int CLOCK_SPEED = 100000,
    parameter int CPU_SPEED   = 500,
    parameter int TICK_RATE   = 60,
    parameter int NUM_TIMERS  = 2,
    parameter int WIDTH       = 8,
    localparam int SEL_W      = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  cpu_tick,
    output logic                  rate_tick,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [WIDTH-1:0]      rd_data,
    output logic [NUM_TIMERS-1:0] active,
    output logic [NUM_TIMERS-1:0] expired
);

    localparam int CPU_DIV  = CLOCK_SPEED / CPU_SPEED + 1;
    localparam int RATE_DIV = CLOCK_SPEED / TICK_RATE + 1;
    localparam int CPU_W    = $clog2(CPU_DIV);
    localparam int RATE_W   = $clog2(RATE_DIV);

    logic [CPU_W-1:0]  cpu_cnt;
    logic [RATE_W-1:0] rate_cnt;
    logic [WIDTH-1:0]  value [NUM_TIMERS];

    // Both prescalers freeze together while paused so their phase is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_cnt  <= '0;
            rate_cnt <= '0;
        end else if (run) begin
            cpu_cnt  <= (cpu_cnt == CPU_W'(CPU_DIV - 1)) ? '0 : cpu_cnt + CPU_W'(1);
            rate_cnt <= (rate_cnt == RATE_W'(RATE_DIV - 1)) ? '0 : rate_cnt + RATE_W'(1);
        end
    end

    assign cpu_tick  = (cpu_cnt == '0) & run & ~rst;
    assign rate_tick = (rate_cnt == '0) & run & ~rst;

    // A write to a timer overrides that cycle's decrement and suppresses its expiry pulse.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (rst) begin
                value[k]   <= '0;
                expired[k] <= 1'b0;
            end else begin
                expired[k] <= 1'b0;
                if (wr_en && wr_sel == SEL_W'(k)) begin
                    value[k] <= wr_data;
                end else if (rate_tick && value[k] != '0) begin
                    value[k] <= value[k] - WIDTH'(1);
                    expired[k] <= (value[k] == WIDTH'(1));
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        active  = '0;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            active[k] = (value[k] != '0);
            if (rd_sel == SEL_W'(k)) rd_data = value[k];
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - self-checking bench for timer_bank against a behavioural model
module tb_timer_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default-parameter instance
    logic       rst0 = 1'b1, run0 = 1'b1, wr_en0 = 1'b0;
    logic [0:0] wr_sel0 = '0, rd_sel0 = '0;
    logic [7:0] wr_data0 = '0, rd_data0;
    logic       cpu_tick0, rate_tick0;
    logic [1:0] active0, expired0;

    timer_bank dut0 (
        .clk(clk), .rst(rst0), .run(run0),
        .cpu_tick(cpu_tick0), .rate_tick(rate_tick0),
        .wr_en(wr_en0), .wr_sel(wr_sel0), .wr_data(wr_data0),
        .rd_sel(rd_sel0), .rd_data(rd_data0),
        .active(active0), .expired(expired0)
    );

    // fast three-timer instance: CPU_DIV = 11, RATE_DIV = 9
    localparam int D1_CPU  = 11;
    localparam int D1_RATE = 9;
    logic       rst1 = 1'b1, run1 = 1'b1, wr_en1 = 1'b0;
    logic [1:0] wr_sel1 = '0, rd_sel1 = '0;
    logic [7:0] wr_data1 = '0, rd_data1;
    logic       cpu_tick1, rate_tick1;
    logic [2:0] active1, expired1;

    timer_bank #(
        .CLOCK_SPEED(1000), .CPU_SPEED(100), .TICK_RATE(125),
        .NUM_TIMERS(3), .WIDTH(8)
    ) dut1 (
        .clk(clk), .rst(rst1), .run(run1),
        .cpu_tick(cpu_tick1), .rate_tick(rate_tick1),
        .wr_en(wr_en1), .wr_sel(wr_sel1), .wr_data(wr_data1),
        .rd_sel(rd_sel1), .rd_data(rd_data1),
        .active(active1), .expired(expired1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of dut1: ticks come from the number of running cycles since reset.
    int         cpu_runs = 0, rate_runs = 0;
    logic [7:0] mv [3];
    logic [2:0] mexp = '0;
    bit         mvalid = 0;

    always @(negedge clk) begin
        bit e_cpu, e_rate, wr;
        e_cpu  = run1 && !rst1 && (cpu_runs % D1_CPU == 0);
        e_rate = run1 && !rst1 && (rate_runs % D1_RATE == 0);
        if (mvalid) begin
            chk("m_cpu_tick", int'(cpu_tick1), int'(e_cpu));
            chk("m_rate_tick", int'(rate_tick1), int'(e_rate));
            chk("m_rd_data", int'(rd_data1), (rd_sel1 < 3) ? int'(mv[rd_sel1]) : 0);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("m_active%0d", k), int'(active1[k]), int'(mv[k] != 0));
                chk($sformatf("m_expired%0d", k), int'(expired1[k]), int'(mexp[k]));
            end
        end
        if (rst1) begin
            cpu_runs = 0;
            rate_runs = 0;
            mexp = '0;
            for (int k = 0; k < 3; k++) mv[k] = '0;
            mvalid = 1;
        end else if (mvalid) begin
            for (int k = 0; k < 3; k++) begin
                wr = wr_en1 && (wr_sel1 == k);
                mexp[k] = e_rate && (mv[k] == 1) && !wr;
                if (wr) mv[k] = wr_data1;
                else if (e_rate && mv[k] != 0) mv[k] = mv[k] - 8'd1;
            end
            if (run1) begin
                cpu_runs++;
                rate_runs++;
            end
        end
    end

    task automatic wait_rate0();
        int n = 0;
        do begin step(); n++; end while (!rate_tick0 && n < 2000);
        chk("wait_rate0", int'(rate_tick0), 1);
    endtask

    task automatic wait_rate1();
        int n = 0;
        do begin step(); n++; end while (!rate_tick1 && n < 40);
        chk("wait_rate1", int'(rate_tick1), 1);
    endtask

    task automatic write1(input logic [1:0] sel, input logic [7:0] data);
        wr_en1 = 1'b1; wr_sel1 = sel; wr_data1 = data;
        step();
        wr_en1 = 1'b0;
    endtask

    initial begin
        int n;
        step(); step();

        // Default prescalers: tick phase measured from release of reset.
        rst0 = 1'b0;
        #1;
        chk("reset_active0", int'(active0), 0);
        chk("reset_expired0", int'(expired0), 0);
        chk("reset_rd0", int'(rd_data0), 0);
        for (int i = 0; i < 12000; i++) begin
            chk("d0_cpu_tick", int'(cpu_tick0), int'(i % 201 == 0));
            chk("d0_rate_tick", int'(rate_tick0), int'(i % 1667 == 0));
            step();
        end

        // Timer 0 loaded with 3 just after a rate tick, counts out over three ticks.
        wait_rate0();
        step();
        wr_en0 = 1'b1; wr_sel0 = 1'b0; wr_data0 = 8'd3;
        step();
        wr_en0 = 1'b0;
        chk("d0_load_rd", int'(rd_data0), 3);
        chk("d0_load_active", int'(active0[0]), 1);
        for (int t = 2; t >= 0; t--) begin
            wait_rate0();
            chk("d0_pre_expired", int'(expired0[0]), 0);
            step();
            chk("d0_count_rd", int'(rd_data0), t);
        end
        chk("d0_expired_pulse", int'(expired0[0]), 1);
        step();
        chk("d0_expired_clear", int'(expired0[0]), 0);
        chk("d0_inactive", int'(active0[0]), 0);

        // dut1: release reset, first ticks immediately.
        rst1 = 1'b0;
        #1;
        chk("d1_first_cpu", int'(cpu_tick1), 1);
        chk("d1_first_rate", int'(rate_tick1), 1);

        // Write coincident with rate tick wins over the decrement.
        rd_sel1 = 2'd1;
        write1(2'd1, 8'd5);
        wait_rate1();
        chk("d1_hold5", int'(rd_data1), 5);
        write1(2'd1, 8'h10);
        chk("d1_write_wins", int'(rd_data1), 16);
        write1(2'd1, 8'd1);
        wait_rate1();
        write1(2'd1, 8'd5);
        chk("d1_reload_rd", int'(rd_data1), 5);
        chk("d1_no_expired", int'(expired1[1]), 0);

        // Pause at cpu phase 5; ticks stop, writes land, phase resumes.
        n = 0;
        do begin step(); n++; end while (!cpu_tick1 && n < 40);
        chk("wait_cpu1", int'(cpu_tick1), 1);
        for (int i = 0; i < 5; i++) step();
        run1 = 1'b0;
        rd_sel1 = 2'd0;
        write1(2'd0, 8'd9);
        for (int i = 0; i < 50; i++) begin
            chk("pause_cpu", int'(cpu_tick1), 0);
            chk("pause_rate", int'(rate_tick1), 0);
            step();
        end
        chk("pause_hold", int'(rd_data1), 9);
        run1 = 1'b1;
        n = 0;
        do begin step(); n++; end while (!cpu_tick1 && n < 40);
        chk("resume_latency", n, 6);

        // Reset mid-count clears everything without an expiry pulse.
        write1(2'd0, 8'd200);
        for (int i = 0; i < 20; i++) step();
        rst1 = 1'b1;
        #1;
        chk("rst_cpu_gated", int'(cpu_tick1), 0);
        chk("rst_rate_gated", int'(rate_tick1), 0);
        step();
        rst1 = 1'b0;
        #1;
        chk("rst_rd", int'(rd_data1), 0);
        chk("rst_active", int'(active1), 0);
        chk("rst_expired", int'(expired1), 0);
        chk("rst_cpu_resume", int'(cpu_tick1), 1);
        chk("rst_rate_resume", int'(rate_tick1), 1);

        // Out-of-range select and writing zero.
        write1(2'd3, 8'hAA);
        rd_sel1 = 2'd3;
        #1;
        chk("sel3_rd", int'(rd_data1), 0);
        chk("sel3_active", int'(active1), 0);
        write1(2'd2, 8'd7);
        chk("t2_active", int'(active1[2]), 1);
        write1(2'd2, 8'd0);
        chk("t2_cleared", int'(active1[2]), 0);
        chk("t2_no_expired", int'(expired1[2]), 0);
        step();
        chk("t2_no_expired_late", int'(expired1[2]), 0);

        // Randomised traffic checked by the model every cycle.
        for (int i = 0; i < 6000; i++) begin
            rst1     = ($urandom % 200 == 0);
            run1     = ($urandom % 10 != 0);
            wr_en1   = ($urandom % 6 == 0);
            wr_sel1  = 2'($urandom % 4);
            wr_data1 = ($urandom % 4 == 0) ? 8'($urandom % 256) : 8'($urandom % 4);
            rd_sel1  = 2'($urandom % 4);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
